// File: rtl/run_sequencer_pkg.sv
// Shared types and constants for the run sequencer: FSM state encoding and
// the widths of the run identifier and init-window counter.
package run_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INIT   = 2'd1,
    RUN    = 2'd2,
    REPORT = 2'd3
  } seq_state_t;

  localparam int RUN_ID_W = 8;
  localparam int INIT_W   = 8;

endpackage

// File: rtl/run_sequencer_if.sv
// Host/datapath-facing bundle of the run sequencer. The master side is the
// host plus datapath environment; the slave side is the sequencer itself.
interface run_sequencer_if
  import run_sequencer_pkg::*;
#(
  parameter int CNT_W = 16
);

  logic                run_req;
  logic                run_ack;
  logic                abort;
  logic                START;
  logic                DONE;
  logic                busy;
  logic                res_valid;
  logic                res_ready;
  logic [CNT_W-1:0]    res_cycles;
  logic                res_timeout;
  logic                res_aborted;
  logic [RUN_ID_W-1:0] run_id;

  modport master (
    output run_req, abort, DONE, res_ready,
    input  run_ack, START, busy, res_valid, res_cycles, res_timeout,
           res_aborted, run_id
  );

  modport slave (
    input  run_req, abort, DONE, res_ready,
    output run_ack, START, busy, res_valid, res_cycles, res_timeout,
           res_aborted, run_id
  );

endinterface

// File: rtl/run_sequencer.sv
// Run controller: holds datapath START for an init window, counts RUN cycles
// until DONE, abort or watchdog, then reports a result record over valid/ready.
//
// state  | meaning
// IDLE   | datapath held in init, waiting for run_req
// INIT   | START held high for INIT_CYCLES after acceptance
// RUN    | START low, counting cycles, watching DONE/abort/watchdog
// REPORT | result record valid, datapath re-held, waiting for res_ready
module run_sequencer
  import run_sequencer_pkg::*;
#(
  parameter int               INIT_CYCLES = 2,
  parameter int               CNT_W       = 16,
  parameter logic [CNT_W-1:0] TIMEOUT     = {CNT_W{1'b1}}
) (
  input logic            CLK,
  input logic            reset_n,
  run_sequencer_if.slave bus
);

  localparam logic [INIT_W-1:0] INIT_LOAD = INIT_W'(INIT_CYCLES - 1);

  seq_state_t          state_q;
  logic [INIT_W-1:0]   init_cnt_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                start_q;
  logic                run_ack_q;
  logic                busy_q;
  logic                res_valid_q;
  logic [CNT_W-1:0]    res_cycles_q;
  logic                res_timeout_q;
  logic                res_aborted_q;
  logic [RUN_ID_W-1:0] run_id_q;

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      init_cnt_q    <= '0;
      cnt_q         <= '0;
      start_q       <= 1'b1;
      run_ack_q     <= 1'b0;
      busy_q        <= 1'b0;
      res_valid_q   <= 1'b0;
      res_cycles_q  <= '0;
      res_timeout_q <= 1'b0;
      res_aborted_q <= 1'b0;
      run_id_q      <= '0;
    end else begin
      run_ack_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.run_req) begin
            state_q       <= INIT;
            run_ack_q     <= 1'b1;
            busy_q        <= 1'b1;
            run_id_q      <= run_id_q + 1'b1;
            cnt_q         <= '0;
            res_cycles_q  <= '0;
            res_timeout_q <= 1'b0;
            res_aborted_q <= 1'b0;
            init_cnt_q    <= INIT_LOAD;
          end
        end
        INIT: begin
          if (bus.abort) begin
            state_q       <= REPORT;
            busy_q        <= 1'b0;
            res_valid_q   <= 1'b1;
            res_aborted_q <= 1'b1;
            res_cycles_q  <= '0;
          end else if (init_cnt_q == '0) begin
            state_q <= RUN;
            start_q <= 1'b0;
          end else begin
            init_cnt_q <= init_cnt_q - 1'b1;
          end
        end
        RUN: begin
          // Priority DONE > abort > watchdog; the watchdog check precedes
          // the increment so the counter can never wrap.
          if (bus.DONE || bus.abort || (cnt_q == TIMEOUT)) begin
            state_q       <= REPORT;
            start_q       <= 1'b1;
            busy_q        <= 1'b0;
            res_valid_q   <= 1'b1;
            res_cycles_q  <= cnt_q;
            res_aborted_q <= !bus.DONE && bus.abort;
            res_timeout_q <= !bus.DONE && !bus.abort;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        REPORT: begin
          if (bus.res_ready) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.START       = start_q;
  assign bus.run_ack     = run_ack_q;
  assign bus.busy        = busy_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_cycles  = res_cycles_q;
  assign bus.res_timeout = res_timeout_q;
  assign bus.res_aborted = res_aborted_q;
  assign bus.run_id      = run_id_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Self-checking bench for run_sequencer: expected result records are queued
// when a run is stimulated and compared when the sequencer presents them.
module tb_run_sequencer;

  typedef struct packed {
    logic [15:0] cycles;
    logic        timeout;
    logic        aborted;
    logic [7:0]  id;
  } res_t;

  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];
  logic [7:0] exp_id = 8'd0;

  run_sequencer_if #(.CNT_W(16)) bus ();

  run_sequencer #(
    .INIT_CYCLES(2),
    .CNT_W      (16),
    .TIMEOUT    (16'd20)
  ) dut (
    .CLK    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic res_t observed();
    return res_t'({bus.res_cycles, bus.res_timeout, bus.res_aborted, bus.run_id});
  endfunction

  // Request a run and advance to the first RUN cycle (after edge k+2).
  task automatic start_run();
    bus.run_req = 1'b1;
    tick();
    bus.run_req = 1'b0;
    exp_id = exp_id + 8'd1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.START, bus.run_ack, bus.busy, bus.res_valid, bus.res_cycles,
         bus.res_timeout, bus.res_aborted, bus.run_id} !== {4'b1000, 16'd0, 2'b00, 8'd0}) begin
      errors++;
      $display("FAIL reset_values: START=%b ack=%b busy=%b valid=%b cyc=%0d to=%b ab=%b id=%0d",
               bus.START, bus.run_ack, bus.busy, bus.res_valid, bus.res_cycles,
               bus.res_timeout, bus.res_aborted, bus.run_id);
    end
    reset_n = 1'b1;
    bus.DONE = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.DONE = 1'b0;
    bus.abort = 1'b0;
    checks++;
    if ({bus.busy, bus.res_valid, bus.START} !== 3'b001) begin
      errors++;
      $display("FAIL idle_ignores_done_abort: busy=%b valid=%b START=%b need 0 0 1",
               bus.busy, bus.res_valid, bus.START);
    end
  endtask

  task automatic test_nominal();
    res_t e;
    bus.run_req = 1'b1;
    tick();
    bus.run_req = 1'b0;
    exp_id = exp_id + 8'd1;
    exp_q.push_back('{cycles: 16'd9, timeout: 1'b0, aborted: 1'b0, id: exp_id});
    checks++;
    if ({bus.run_ack, bus.busy, bus.START} !== 3'b111) begin
      errors++;
      $display("FAIL nominal_accept: ack=%b busy=%b START=%b need 1 1 1",
               bus.run_ack, bus.busy, bus.START);
    end
    tick();
    checks++;
    if ({bus.run_ack, bus.START} !== 2'b01) begin
      errors++;
      $display("FAIL nominal_init2: ack=%b START=%b need 0 1", bus.run_ack, bus.START);
    end
    tick();
    checks++;
    if (bus.START !== 1'b0) begin
      errors++;
      $display("FAIL nominal_start_fall: START=%b need 0", bus.START);
    end
    for (int i = 1; i <= 9; i++) tick();
    checks++;
    if ({bus.START, bus.busy, bus.res_valid} !== 3'b010) begin
      errors++;
      $display("FAIL nominal_running: START=%b busy=%b valid=%b need 0 1 0",
               bus.START, bus.busy, bus.res_valid);
    end
    bus.DONE = 1'b1;
    tick();
    bus.DONE = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (bus.res_valid !== 1'b1 || observed() !== e || bus.START !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL nominal_result: valid=%b got %h need %h START=%b busy=%b",
               bus.res_valid, observed(), e, bus.START, bus.busy);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    checks++;
    if (bus.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL nominal_release: valid=%b need 0", bus.res_valid);
    end
  endtask

  task automatic test_timeout();
    res_t e;
    int   n = 0;
    start_run();
    exp_q.push_back('{cycles: 16'd20, timeout: 1'b1, aborted: 1'b0, id: exp_id});
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus.res_valid === 1'b1) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n != 21) begin
      errors++;
      $display("FAIL timeout_edges: res_valid after %0d RUN edges need 21 (0 = never)", n);
    end
    e = exp_q.pop_front();
    checks++;
    if (observed() !== e || bus.START !== 1'b1) begin
      errors++;
      $display("FAIL timeout_result: got %h need %h START=%b", observed(), e, bus.START);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  task automatic test_done_abort();
    res_t e;
    start_run();
    exp_q.push_back('{cycles: 16'd4, timeout: 1'b0, aborted: 1'b0, id: exp_id});
    for (int i = 1; i <= 4; i++) tick();
    bus.DONE  = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.DONE  = 1'b0;
    bus.abort = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (bus.res_valid !== 1'b1 || observed() !== e) begin
      errors++;
      $display("FAIL done_beats_abort: valid=%b got %h need %h", bus.res_valid, observed(), e);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  task automatic test_abort_run();
    res_t e;
    start_run();
    exp_q.push_back('{cycles: 16'd6, timeout: 1'b0, aborted: 1'b1, id: exp_id});
    for (int i = 1; i <= 6; i++) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (bus.res_valid !== 1'b1 || observed() !== e) begin
      errors++;
      $display("FAIL abort_run: valid=%b got %h need %h", bus.res_valid, observed(), e);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  task automatic test_abort_init();
    res_t e;
    logic start_low = 1'b0;
    bus.run_req = 1'b1;
    tick();
    bus.run_req = 1'b0;
    exp_id = exp_id + 8'd1;
    exp_q.push_back('{cycles: 16'd0, timeout: 1'b0, aborted: 1'b1, id: exp_id});
    if (bus.START !== 1'b1) start_low = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    if (bus.START !== 1'b1) start_low = 1'b1;
    e = exp_q.pop_front();
    checks++;
    if (bus.res_valid !== 1'b1 || observed() !== e || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_init_result: valid=%b got %h need %h busy=%b",
               bus.res_valid, observed(), e, bus.busy);
    end
    tick();
    if (bus.START !== 1'b1) start_low = 1'b1;
    checks++;
    if (start_low !== 1'b0) begin
      errors++;
      $display("FAIL abort_init_start: START dropped low, need held high");
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    res_t e;
    int   bad = 0;
    start_run();
    exp_q.push_back('{cycles: 16'd2, timeout: 1'b0, aborted: 1'b0, id: exp_id});
    tick();
    tick();
    bus.DONE = 1'b1;
    tick();
    bus.DONE = 1'b0;
    bus.run_req = 1'b1;
    e = exp_q.pop_front();
    for (int i = 0; i < 7; i++) begin
      if (bus.res_valid !== 1'b1 || observed() !== e || bus.run_ack !== 1'b0) begin
        bad++;
        $display("FAIL backpressure_hold: cycle %0d valid=%b got %h need %h ack=%b",
                 i, bus.res_valid, observed(), e, bus.run_ack);
      end
      tick();
    end
    checks++;
    if (bad != 0) errors++;
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    checks++;
    if ({bus.res_valid, bus.run_ack, bus.busy} !== 3'b000) begin
      errors++;
      $display("FAIL release_to_idle: valid=%b ack=%b busy=%b need 0 0 0",
               bus.res_valid, bus.run_ack, bus.busy);
    end
    tick();
    bus.run_req = 1'b0;
    exp_id = exp_id + 8'd1;
    exp_q.push_back('{cycles: 16'd0, timeout: 1'b0, aborted: 1'b0, id: exp_id});
    checks++;
    if (bus.run_ack !== 1'b1 || bus.run_id !== exp_id) begin
      errors++;
      $display("FAIL back_to_back_accept: ack=%b id=%0d need 1 %0d", bus.run_ack, bus.run_id, exp_id);
    end
    tick();
    tick();
    bus.DONE = 1'b1;
    tick();
    bus.DONE = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (bus.res_valid !== 1'b1 || observed() !== e) begin
      errors++;
      $display("FAIL back_to_back_result: valid=%b got %h need %h", bus.res_valid, observed(), e);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    res_t e;
    start_run();
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    exp_id = 8'd0;
    exp_q.delete();
    checks++;
    if ({bus.START, bus.run_ack, bus.busy, bus.res_valid, bus.res_cycles,
         bus.res_timeout, bus.res_aborted, bus.run_id} !== {4'b1000, 16'd0, 2'b00, 8'd0}) begin
      errors++;
      $display("FAIL reset_mid_run: START=%b ack=%b busy=%b valid=%b cyc=%0d to=%b ab=%b id=%0d",
               bus.START, bus.run_ack, bus.busy, bus.res_valid, bus.res_cycles,
               bus.res_timeout, bus.res_aborted, bus.run_id);
    end
    start_run();
    exp_q.push_back('{cycles: 16'd1, timeout: 1'b0, aborted: 1'b0, id: exp_id});
    tick();
    bus.DONE = 1'b1;
    tick();
    bus.DONE = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (bus.res_valid !== 1'b1 || observed() !== e) begin
      errors++;
      $display("FAIL run_after_reset: valid=%b got %h need %h", bus.res_valid, observed(), e);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.run_req   = 1'b0;
    bus.abort     = 1'b0;
    bus.DONE      = 1'b0;
    bus.res_ready = 1'b0;
    test_reset();
    test_nominal();
    test_timeout();
    test_done_abort();
    test_abort_run();
    test_abort_init();
    test_back_to_back();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
